fpadd_rs_sched: RTL and testbench
=================================

# fpadd_rs_sched

Reservation-station scheduler for the double-precision FP add/subtract unit in the Tomasulo core. It accepts issued add/sub instructions, holds them until both operands are available by snooping the common data bus (CDB), and dispatches one at a time to the combinational FP adder. It holds the adder inputs stable for a fixed multicycle latency, then captures the result and requests the CDB for writeback.

## Interface
- DEPTH, 4: reservation-station entries (2..16).
- TAG_W, 4: ROB/RS tag width.
- LAT, 3: cycles adder inputs are held before the result is sampled (≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries and in-flight op.
- iss_valid  in  1  issue request.
- iss_ready  out  1  at least one free entry.
- iss_tag  in  TAG_W  destination tag.
- iss_sub  in  1  1 = subtract.
- iss_a_rdy, iss_b_rdy  in  1  operand value already valid.
- iss_a_val, iss_b_val  in  64  operand value, used when rdy=1.
- iss_a_tag, iss_b_tag  in  TAG_W  producer tag, used when rdy=0.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  64  broadcast value.
- fu_a, fu_b  out  64  adder operands, registered.
- fu_sub  out  1  adder add/sub select, registered.
- fu_res  in  64  adder result.
- wb_req  out  1  result pending for CDB.
- wb_tag  out  TAG_W  result tag.
- wb_data  out  64  result value.
- wb_grant  in  1  CDB arbiter grant.
- occupancy  out  $clog2(DEPTH+1)  valid-entry count.

## Operation
- Entry fields: valid, tag, sub, and per operand rdy, val, qtag.
- Issue: transfer when iss_valid && iss_ready. The instruction goes into the lowest-index free entry.
- Wakeup: every valid entry with a pending operand whose qtag == cdb_tag while cdb_valid captures cdb_data and sets rdy.
  - This includes the entry being written by a same-cycle issue: if the issued operand's tag matches the CDB, it is captured.
- Dispatch: the lowest-index entry with both operands ready is eligible.
  - Requires FSM in IDLE, or in WB with wb_grant this cycle.
  - On dispatch: fu_a/fu_b/fu_sub and the result tag are registered, and the entry is freed in the same cycle.
- FSM states:
  - IDLE: dispatch → EXEC, with cnt = LAT-1.
  - EXEC: if cnt == 0, register fu_res into wb_data and go to WB; otherwise decrement cnt.
  - WB: wb_req = 1. With wb_grant, dispatch if eligible → EXEC, else → IDLE. Without wb_grant, hold with outputs stable.
- wb_tag/wb_data are constant while wb_req = 1.
- Freed entries are reusable for issue in the next cycle. iss_ready is computed from current-cycle state only.
- Flush: at the next edge, all entries are invalid, the FSM is in IDLE and wb_req = 0. Flush overrides issue, wakeup and grant in the same cycle.
- Reset values: entries invalid, FSM IDLE, cnt 0, wb_req 0, wb_tag 0, wb_data 0, fu_a 0, fu_b 0, fu_sub 0, occupancy 0, iss_ready 1.

## Timing
- Issue with both operands ready at edge t → entry valid at t+1 → dispatch at t+1 → fu_* valid at t+2 → wb_req rises at t+2+LAT.
- Back-to-back: a grant at cycle g with an eligible entry → next wb_req at g+1+LAT. One op in flight at a time.
- Wakeup to dispatch: 1 cycle minimum (without the bypass below).
- When full, iss_ready = 0. Simultaneous dispatch and issue when full is not accepted that cycle.
- Reset asserted mid-EXEC/WB: immediate return to reset values; no partial writeback.

## Configuration
- FPADD_RS_WAKEUP_BYPASS_EN defined: an entry whose last missing operand matches the CDB this cycle is dispatch-eligible in the same cycle.
  - In that case cdb_data is forwarded directly into fu_a/fu_b.
  - Wakeup to dispatch: 0 cycles.
- Not defined: a captured operand becomes eligible the cycle after capture.

## Structure
- Shared package fpadd_pkg:
  - FSM state enum (IDLE, EXEC, WB).
  - Entry struct type (valid, tag, sub, operand rdy/val/qtag).
  - Constant FP_W = 64.
- One sub-module, fpadd_rs_pick: lowest-index one-hot priority picker, used for both free-entry allocation and ready-entry selection.

## Test plan
- Reset, then issue tag 3, sub 0, a = 0x3FF0000000000000, b = 0x4000000000000000 (both ready), LAT=3 → fu_a/fu_b driven 2 cycles after issue; wb_req at issue+5 with wb_tag 3 and wb_data = fu_res.
- Issue tag 1 with b waiting on tag 7; broadcast cdb_tag 7 = 0x4008000000000000 two cycles later → dispatch the cycle after the broadcast with fu_b = 0x4008000000000000 (same cycle under FPADD_RS_WAKEUP_BYPASS_EN).
- Fill DEPTH=4 entries with blocked operands → iss_ready 0, occupancy 4; wake entry 2 → it dispatches first, then iss_ready returns to 1.
- Hold wb_grant low for 5 cycles in WB → wb_tag/wb_data stable, no new dispatch; grant with an eligible entry → WB→EXEC in one cycle.
- Issue with an operand tag equal to the same-cycle CDB tag → operand captured, no deadlock.
- Flush during EXEC with 3 entries valid → next cycle occupancy 0, wb_req 0, FSM IDLE, and no writeback afterwards.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types for the FP add/sub reservation-station scheduler.
package fpadd_pkg;

    localparam int FP_W      = 64;
    localparam int TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Tags are stored zero-extended to TAG_W_MAX so the entry layout is fixed.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic                 sub;
        logic                 a_rdy;
        logic [FP_W-1:0]      a_val;
        logic [TAG_W_MAX-1:0] a_qtag;
        logic                 b_rdy;
        logic [FP_W-1:0]      b_val;
        logic [TAG_W_MAX-1:0] b_qtag;
    } rs_entry_t;

endpackage

// File: rtl/fpadd_rs_pick.sv
// Lowest-index one-hot priority picker.
module fpadd_rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // req & -req isolates the least significant set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;

endmodule

// File: rtl/fpadd_rs_sched.sv
// Reservation-station scheduler for the multicycle FP add/sub unit.
// Optional: define FPADD_RS_WAKEUP_BYPASS_EN for same-cycle CDB wakeup-to-dispatch.
module fpadd_rs_sched
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int LAT   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic [TAG_W-1:0]           iss_tag,
    input  logic                       iss_sub,
    input  logic                       iss_a_rdy,
    input  logic                       iss_b_rdy,
    input  logic [63:0]                iss_a_val,
    input  logic [63:0]                iss_b_val,
    input  logic [TAG_W-1:0]           iss_a_tag,
    input  logic [TAG_W-1:0]           iss_b_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [63:0]                cdb_data,
    output logic [63:0]                fu_a,
    output logic [63:0]                fu_b,
    output logic                       fu_sub,
    input  logic [63:0]                fu_res,
    output logic                       wb_req,
    output logic [TAG_W-1:0]           wb_tag,
    output logic [63:0]                wb_data,
    input  logic                       wb_grant,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    rs_entry_t              ent     [DEPTH];
    rs_entry_t              ent_nxt [DEPTH];
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [TAG_W-1:0]       res_tag;

    logic [DEPTH-1:0]       free_vec, alloc_oh, elig_vec, disp_oh;
    logic [DEPTH-1:0]       wake_a, wake_b;
    logic                   any_free, any_elig;
    logic                   can_disp, do_disp, do_iss, capture;
    logic [FP_W-1:0]        disp_a, disp_b;
    logic                   disp_sub;
    logic [TAG_W_MAX-1:0]   cdb_tag_x;
    logic                   iss_a_hit, iss_b_hit;

    assign cdb_tag_x = TAG_W_MAX'(cdb_tag);
    assign iss_a_hit = cdb_valid && (iss_a_tag == cdb_tag);
    assign iss_b_hit = cdb_valid && (iss_b_tag == cdb_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !ent[i].valid;
            wake_a[i]   = ent[i].valid && !ent[i].a_rdy && cdb_valid && (ent[i].a_qtag == cdb_tag_x);
            wake_b[i]   = ent[i].valid && !ent[i].b_rdy && cdb_valid && (ent[i].b_qtag == cdb_tag_x);
`ifdef FPADD_RS_WAKEUP_BYPASS_EN
            elig_vec[i] = ent[i].valid && (ent[i].a_rdy || wake_a[i]) && (ent[i].b_rdy || wake_b[i]);
`else
            elig_vec[i] = ent[i].valid && ent[i].a_rdy && ent[i].b_rdy;
`endif
        end
    end

    fpadd_rs_pick #(.N(DEPTH)) u_pick_free (.req(free_vec), .gnt(alloc_oh), .any(any_free));
    fpadd_rs_pick #(.N(DEPTH)) u_pick_rdy  (.req(elig_vec), .gnt(disp_oh),  .any(any_elig));

    assign iss_ready = any_free;
    assign can_disp  = (state == IDLE) || (state == WB && wb_grant);
    assign do_disp   = can_disp && any_elig && !flush;
    assign do_iss    = iss_valid && iss_ready && !flush;
    assign wb_req    = (state == WB);

    // Operand mux for the selected entry; a not-yet-captured operand can only be the CDB value.
    always_comb begin
        disp_a   = '0;
        disp_b   = '0;
        disp_sub = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_oh[i]) begin
                disp_a   = ent[i].a_rdy ? ent[i].a_val : cdb_data;
                disp_b   = ent[i].b_rdy ? ent[i].b_val : cdb_data;
                disp_sub = ent[i].sub;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt[i] = ent[i];
            if (wake_a[i]) begin
                ent_nxt[i].a_rdy = 1'b1;
                ent_nxt[i].a_val = cdb_data;
            end
            if (wake_b[i]) begin
                ent_nxt[i].b_rdy = 1'b1;
                ent_nxt[i].b_val = cdb_data;
            end
            if (do_disp && disp_oh[i])
                ent_nxt[i].valid = 1'b0;
            if (do_iss && alloc_oh[i]) begin
                ent_nxt[i].valid  = 1'b1;
                ent_nxt[i].tag    = TAG_W_MAX'(iss_tag);
                ent_nxt[i].sub    = iss_sub;
                ent_nxt[i].a_rdy  = iss_a_rdy || iss_a_hit;
                ent_nxt[i].a_val  = iss_a_rdy ? iss_a_val : cdb_data;
                ent_nxt[i].a_qtag = TAG_W_MAX'(iss_a_tag);
                ent_nxt[i].b_rdy  = iss_b_rdy || iss_b_hit;
                ent_nxt[i].b_val  = iss_b_rdy ? iss_b_val : cdb_data;
                ent_nxt[i].b_qtag = TAG_W_MAX'(iss_b_tag);
            end
            if (flush)
                ent_nxt[i].valid = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (do_disp) begin
                    state_nxt = EXEC;
                    cnt_nxt   = CNT_W'(LAT-1);
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = WB;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WB: begin
                if (wb_grant) begin
                    if (do_disp) begin
                        state_nxt = EXEC;
                        cnt_nxt   = CNT_W'(LAT-1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= ent_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fu_a    <= '0;
            fu_b    <= '0;
            fu_sub  <= 1'b0;
            res_tag <= '0;
            wb_tag  <= '0;
            wb_data <= '0;
        end else begin
            if (do_disp) begin
                fu_a   <= disp_a;
                fu_b   <= disp_b;
                fu_sub <= disp_sub;
                for (int i = 0; i < DEPTH; i++)
                    if (disp_oh[i])
                        res_tag <= ent[i].tag[TAG_W-1:0];
            end
            if (capture) begin
                wb_tag  <= res_tag;
                wb_data <= fu_res;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + OCC_W'(ent[i].valid);
    end

endmodule

// File: tb/tb_fpadd_rs_sched.sv
// Directed self-checking bench for fpadd_rs_sched (DEPTH=4, TAG_W=4, LAT=3).
module tb_fpadd_rs_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_tag;
    logic        iss_sub;
    logic        iss_a_rdy, iss_b_rdy;
    logic [63:0] iss_a_val, iss_b_val;
    logic [3:0]  iss_a_tag, iss_b_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic [63:0] fu_a, fu_b, fu_res;
    logic        fu_sub;
    logic        wb_req;
    logic [3:0]  wb_tag;
    logic [63:0] wb_data;
    logic        wb_grant;
    logic [2:0]  occupancy;

    int nrun  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    // Stand-in adder: integer add/sub keeps expected results easy to hand-compute.
    assign fu_res = fu_sub ? (fu_a - fu_b) : (fu_a + fu_b);

    fpadd_rs_sched #(.DEPTH(4), .TAG_W(4), .LAT(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag), .iss_sub(iss_sub),
        .iss_a_rdy(iss_a_rdy), .iss_b_rdy(iss_b_rdy),
        .iss_a_val(iss_a_val), .iss_b_val(iss_b_val),
        .iss_a_tag(iss_a_tag), .iss_b_tag(iss_b_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub), .fu_res(fu_res),
        .wb_req(wb_req), .wb_tag(wb_tag), .wb_data(wb_data), .wb_grant(wb_grant),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] tag, input logic sub,
                         input logic ar, input logic [63:0] av, input logic [3:0] aq,
                         input logic br, input logic [63:0] bv, input logic [3:0] bq);
        iss_valid = 1'b1; iss_tag = tag; iss_sub = sub;
        iss_a_rdy = ar; iss_a_val = av; iss_a_tag = aq;
        iss_b_rdy = br; iss_b_val = bv; iss_b_tag = bq;
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [63:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    endtask

    task automatic wait_wb;
        for (int k = 0; k < 20 && !wb_req; k++)
            step();
        chk("wb_timeout", wb_req, 1);
    endtask

    task automatic grant_one;
        wb_grant = 1'b1;
        step();
        wb_grant = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_grant = 1'b0;
        iss_valid = 1'b0; iss_tag = '0; iss_sub = 1'b0;
        iss_a_rdy = 1'b0; iss_b_rdy = 1'b0; iss_a_val = '0; iss_b_val = '0;
        iss_a_tag = '0; iss_b_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_iss_ready", iss_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fu_a", fu_a, 0);

        // Both operands ready: fu at +2, wb_req at +5.
        issue(4'd3, 1'b0, 1'b1, 64'h3FF0000000000000, 4'd0, 1'b1, 64'h4000000000000000, 4'd0);
        step(); iss_valid = 1'b0;
        chk("t1_occ", occupancy, 1);
        step();
        chk("t1_fu_a", fu_a, 64'h3FF0000000000000);
        chk("t1_fu_b", fu_b, 64'h4000000000000000);
        chk("t1_fu_sub", fu_sub, 0);
        chk("t1_occ_free", occupancy, 0);
        step(); step();
        chk("t1_wb_early", wb_req, 0);
        step();
        chk("t1_wb_req", wb_req, 1);
        chk("t1_wb_tag", wb_tag, 3);
        chk("t1_wb_data", wb_data, 64'h7FF0000000000000);
        grant_one();
        chk("t1_wb_drop", wb_req, 0);

        // Operand b waits on tag 7, broadcast two cycles after issue.
        issue(4'd1, 1'b0, 1'b1, 64'h3FF0000000000000, 4'd0, 1'b0, 64'h0, 4'd7);
        step(); iss_valid = 1'b0;
        step(); bcast(4'd7, 64'h4008000000000000);
        step(); cdb_valid = 1'b0;
`ifdef FPADD_RS_WAKEUP_BYPASS_EN
        chk("t2_fu_b_c3", fu_b, 64'h4008000000000000);
`else
        chk("t2_fu_b_c3", fu_b, 64'h4000000000000000);
`endif
        step();
        chk("t2_fu_b", fu_b, 64'h4008000000000000);
        chk("t2_fu_a", fu_a, 64'h3FF0000000000000);
        wait_wb();
        chk("t2_wb_tag", wb_tag, 1);
        chk("t2_wb_data", wb_data, 64'h7FF8000000000000);
        grant_one();

        // Fill all entries with b blocked on tags 8..11.
        for (int i = 0; i < 4; i++) begin
            issue(4'(4 + i), 1'b1, 1'b1, 64'h1000 + 64'(i), 4'd0, 1'b0, 64'h0, 4'(8 + i));
            step();
        end
        iss_valid = 1'b0;
        chk("t3_full_ready", iss_ready, 0);
        chk("t3_full_occ", occupancy, 4);
        issue(4'd15, 1'b0, 1'b1, 64'h0, 4'd0, 1'b1, 64'h0, 4'd0);
        step(); iss_valid = 1'b0;
        chk("t3_full_drop", occupancy, 4);
        bcast(4'd10, 64'h2);
        step(); cdb_valid = 1'b0;
        step();
        chk("t3_occ", occupancy, 3);
        chk("t3_ready", iss_ready, 1);
        chk("t3_fu_a", fu_a, 64'h1002);
        chk("t3_fu_b", fu_b, 64'h2);
        chk("t3_fu_sub", fu_sub, 1);
        wait_wb();
        chk("t3_wb_tag", wb_tag, 6);
        chk("t3_wb_data", wb_data, 64'h1000);

        // Hold grant low in WB while entry 0 becomes eligible.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) bcast(4'd8, 64'h1);
            chk("t4_hold_req", wb_req, 1);
            chk("t4_hold_tag", wb_tag, 6);
            chk("t4_hold_data", wb_data, 64'h1000);
            step();
            cdb_valid = 1'b0;
        end
        chk("t4_no_disp_occ", occupancy, 3);
        chk("t4_no_disp_fu", fu_a, 64'h1002);
        grant_one();
        chk("t4_b2b_req", wb_req, 0);
        chk("t4_b2b_fu_a", fu_a, 64'h1000);
        chk("t4_b2b_fu_b", fu_b, 64'h1);
        chk("t4_b2b_occ", occupancy, 2);
        step(); step();
        chk("t4_b2b_early", wb_req, 0);
        step();
        chk("t4_b2b_wb", wb_req, 1);
        chk("t4_b2b_tag", wb_tag, 4);
        chk("t4_b2b_data", wb_data, 64'hFFF);
        grant_one();

        // Issue whose pending operand is on the CDB in the same cycle.
        issue(4'd2, 1'b0, 1'b0, 64'h0, 4'd12, 1'b1, 64'h20, 4'd0);
        bcast(4'd12, 64'h40);
        step(); iss_valid = 1'b0; cdb_valid = 1'b0;
        wait_wb();
        chk("t5_wb_tag", wb_tag, 2);
        chk("t5_wb_data", wb_data, 64'h60);
        chk("t5_occ", occupancy, 2);
        grant_one();

        // Flush during EXEC with three valid entries.
        issue(4'd9, 1'b0, 1'b1, 64'h1, 4'd0, 1'b1, 64'h1, 4'd0);
        step();
        issue(4'd10, 1'b0, 1'b1, 64'h3, 4'd0, 1'b0, 64'h0, 4'd13);
        step(); iss_valid = 1'b0;
        chk("t6_pre_occ", occupancy, 3);
        chk("t6_pre_req", wb_req, 0);
        flush = 1'b1;
        step(); flush = 1'b0;
        chk("t6_occ", occupancy, 0);
        chk("t6_req", wb_req, 0);
        chk("t6_ready", iss_ready, 1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_no_wb", wb_req, 0);
        end
        issue(4'd14, 1'b0, 1'b1, 64'h5, 4'd0, 1'b1, 64'h6, 4'd0);
        step(); iss_valid = 1'b0;
        step(); step(); step();
        chk("t6_post_early", wb_req, 0);
        step();
        chk("t6_post_wb", wb_req, 1);
        chk("t6_post_tag", wb_tag, 14);
        chk("t6_post_data", wb_data, 64'hB);
        grant_one();

        // Asynchronous reset mid-EXEC.
        issue(4'd3, 1'b0, 1'b1, 64'h7, 4'd0, 1'b1, 64'h1, 4'd0);
        step(); iss_valid = 1'b0;
        step();
        chk("t7_fu_a", fu_a, 64'h7);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_fu_a", fu_a, 0);
        chk("t7_rst_occ", occupancy, 0);
        chk("t7_rst_req", wb_req, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t7_no_wb", wb_req, 0);
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
